// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; waits for the load response, buffers it under writeback stall.
// Optional MEM_LOAD_STALL_CNT_EN adds a free-running load-stall cycle counter.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 71,
   parameter int MS_TO_WS_BUS_WD = 70
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_allowin,
   input  logic                       ws_allowin,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_sram_rvalid,
   input  logic [31:0]                data_sram_rdata,
   output logic [4:0]                 ms_to_ds_dest,
   output logic                       ms_to_ds_load_pending,
   output logic                       mem_forward_valid,
   output logic [4:0]                 mem_forward_addr,
`ifdef MEM_LOAD_STALL_CNT_EN
   output logic [31:0]                ms_load_stall_cnt,
`endif
   output logic [31:0]                mem_forward_data
);
   typedef enum logic {WAIT, DONE} state_t;
   state_t                     state;
   logic                       ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_bus;
   logic [31:0]                rdata_buf;
   logic                       res_from_mem, gr_we, got_rdata, ms_ready_go;
   logic [4:0]                 dest;
   logic [31:0]                alu_result, pc, final_result;

   assign {res_from_mem, gr_we, dest, alu_result, pc} = es_bus;
   assign got_rdata             = state == DONE;
   assign ms_ready_go           = !res_from_mem || data_sram_rvalid || got_rdata;
   assign ms_to_ws_valid        = ms_valid && ms_ready_go;
   assign ms_allowin            = !ms_valid || (ms_ready_go && ws_allowin);
   assign final_result          = !res_from_mem ? alu_result : got_rdata ? rdata_buf : data_sram_rdata;
   assign ms_to_ws_bus          = {gr_we, dest, final_result, pc};
   assign ms_to_ds_dest         = ms_valid ? dest : 5'd0;
   assign ms_to_ds_load_pending = ms_valid && res_from_mem && !ms_ready_go;
   assign mem_forward_valid     = ms_valid && gr_we && ms_ready_go;
   assign mem_forward_addr      = dest;
   assign mem_forward_data      = final_result;

   always_ff @(posedge clk)
      if (es_to_ms_valid && ms_allowin) es_bus <= es_to_ms_bus;

   // A departing instruction always clears the buffer state, so a load entering behind it starts in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid  <= 1'b0;
         state     <= WAIT;
         rdata_buf <= 32'd0;
      end else begin
         if (ms_allowin) ms_valid <= es_to_ms_valid;
         if (ms_to_ws_valid && ws_allowin) state <= WAIT;
         else if (ms_valid && res_from_mem && state == WAIT && data_sram_rvalid) begin
            state     <= DONE;
            rdata_buf <= data_sram_rdata;
         end
      end
   end

`ifdef MEM_LOAD_STALL_CNT_EN
   always_ff @(posedge clk)
      ms_load_stall_cnt <= reset ? 32'd0 : ms_load_stall_cnt + {31'd0, ms_to_ds_load_pending};
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage against a transaction-level model.
module tb_mem_stage;
   logic        clk = 1'b0, reset = 1'b0;
   logic        es_to_ms_valid = 1'b0, ws_allowin = 1'b0;
   logic [70:0] es_to_ms_bus = '0;
   logic        data_sram_rvalid = 1'b0;
   logic [31:0] data_sram_rdata = '0;
   logic        ms_allowin, ms_to_ws_valid, ms_to_ds_load_pending, mem_forward_valid;
   logic [69:0] ms_to_ws_bus;
   logic [4:0]  ms_to_ds_dest, mem_forward_addr;
   logic [31:0] mem_forward_data;
`ifdef MEM_LOAD_STALL_CNT_EN
   logic [31:0] ms_load_stall_cnt;
`endif
   int checks = 0, errors = 0;

   mem_stage dut (
      .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
      .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_to_ws_bus(ms_to_ws_bus), .data_sram_rvalid(data_sram_rvalid), .data_sram_rdata(data_sram_rdata),
      .ms_to_ds_dest(ms_to_ds_dest), .ms_to_ds_load_pending(ms_to_ds_load_pending),
      .mem_forward_valid(mem_forward_valid), .mem_forward_addr(mem_forward_addr),
`ifdef MEM_LOAD_STALL_CNT_EN
      .ms_load_stall_cnt(ms_load_stall_cnt),
`endif
      .mem_forward_data(mem_forward_data)
   );

   always #5 clk = ~clk;

   // Reference: the instruction held in the stage, plus the load data it has collected (if any).
   typedef struct {bit ld; bit we; bit [4:0] dest; bit [31:0] alu; bit [31:0] pc;} insn_t;
   insn_t     held;
   bit        have_insn = 0, have_data = 0;
   bit [31:0] kept_data = 0, stall_cycles = 0;
   bit        e_done, e_take, e_leave;

   function automatic logic [70:0] mk(bit ld, bit we, bit [4:0] d, bit [31:0] alu, bit [31:0] pc);
      return {ld, we, d, alu, pc};
   endfunction

   task automatic check(input string tag, input logic [69:0] o, input logic [69:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic step(input bit rst, input bit ev, input logic [70:0] bus, input bit ws, input bit rv, input logic [31:0] rd);
      bit [31:0] result;
      @(negedge clk);
      reset = rst; es_to_ms_valid = ev; es_to_ms_bus = bus; ws_allowin = ws;
      data_sram_rvalid = rv; data_sram_rdata = rd;
      #1;
      e_done  = have_insn && (!held.ld || have_data || rv);
      e_take  = !have_insn || (e_done && ws);
      e_leave = e_done && ws;
      result  = !held.ld ? held.alu : have_data ? kept_data : rd;
      check("allowin", 70'(ms_allowin), 70'(e_take));
      check("to_ws_valid", 70'(ms_to_ws_valid), 70'(e_done));
      check("ds_dest", 70'(ms_to_ds_dest), 70'(have_insn ? held.dest : 5'd0));
      check("load_pending", 70'(ms_to_ds_load_pending), 70'(have_insn && held.ld && !e_done));
      check("fwd_valid", 70'(mem_forward_valid), 70'(e_done && held.we));
      if (e_done) begin
         check("to_ws_bus", ms_to_ws_bus, {held.we, held.dest, result, held.pc});
         check("fwd_addr", 70'(mem_forward_addr), 70'(held.dest));
         check("fwd_data", 70'(mem_forward_data), 70'(result));
      end
`ifdef MEM_LOAD_STALL_CNT_EN
      check("stall_cnt", 70'(ms_load_stall_cnt), 70'(stall_cycles));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         have_insn = 0; have_data = 0; stall_cycles = 0;
      end else begin
         if (have_insn && held.ld && !e_done) stall_cycles++;
         if (e_leave) have_data = 0;
         else if (have_insn && held.ld && !have_data && data_sram_rvalid) begin
            have_data = 1; kept_data = data_sram_rdata;
         end
         if (e_take) begin
            have_insn = es_to_ms_valid;
            if (es_to_ms_valid)
               held = '{es_to_ms_bus[70], es_to_ms_bus[69], es_to_ms_bus[68:64], es_to_ms_bus[63:32], es_to_ms_bus[31:0]};
         end
      end
   endtask

   task automatic cyc(input bit rst, input bit ev, input logic [70:0] bus, input bit ws, input bit rv, input logic [31:0] rd);
      step(rst, ev, bus, ws, rv, rd);
      tick();
   endtask

   initial begin
      held = '{0, 0, 0, 0, 0};
      cyc(1, 0, '0, 0, 0, 0);
      cyc(1, 0, '0, 0, 0, 0);
      // reset state
      step(0, 0, '0, 1, 0, 0);
      check("rst_allowin", 70'(ms_allowin), 70'(1));
      check("rst_valid", 70'(ms_to_ws_valid), 70'(0));
      check("rst_dest", 70'(ms_to_ds_dest), 70'(0));
      check("rst_pending", 70'(ms_to_ds_load_pending), 70'(0));
      check("rst_fwd", 70'(mem_forward_valid), 70'(0));
      tick();
      // ALU op passes through the cycle after capture
      cyc(0, 1, mk(0, 1, 5, 32'h1234, 32'h1c00_0000), 1, 0, 0);
      step(0, 0, '0, 1, 0, 0);
      check("alu_valid", 70'(ms_to_ws_valid), 70'(1));
      check("alu_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234));
      check("alu_fwd", 70'({mem_forward_valid, mem_forward_addr, mem_forward_data}), 70'({1'b1, 5'd5, 32'h1234}));
      tick();
      // load waits three cycles for rvalid
      cyc(0, 1, mk(1, 1, 7, 32'h100, 32'h1c00_0004), 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, '0, 1, 0, 32'h5555_5555);
         check("ld_pending", 70'({ms_to_ds_load_pending, ms_allowin}), 70'(2'b10));
         tick();
      end
      step(0, 0, '0, 1, 1, 32'hDEAD_BEEF);
      check("ld_valid", 70'(ms_to_ws_valid), 70'(1));
      check("ld_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
`ifdef MEM_LOAD_STALL_CNT_EN
      check("ld_cnt3", 70'(ms_load_stall_cnt), 70'(3));
`endif
      tick();
      // load data buffered across a writeback stall
      cyc(0, 1, mk(1, 1, 3, 32'h200, 32'h1c00_0008), 1, 0, 0);
      cyc(0, 0, '0, 0, 1, 32'hCAFE_F00D);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, '0, 0, 0, 0);
         check("buf_hold", 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
         tick();
      end
      step(0, 0, '0, 1, 0, 0);
      check("buf_xfer", 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
      tick();
      // back-to-back loads: the second must wait for its own data
      cyc(0, 1, mk(1, 1, 4, 0, 32'h10), 1, 0, 0);
      cyc(0, 1, mk(1, 1, 6, 0, 32'h14), 1, 1, 32'h1111_1111);
      step(0, 0, '0, 1, 0, 32'h2222);
      check("b2b_wait", 70'({ms_to_ws_valid, ms_to_ds_load_pending}), 70'(2'b01));
      tick();
      step(0, 0, '0, 1, 1, 32'h3333_3333);
      check("b2b_data", 70'(ms_to_ws_bus[63:32]), 70'(32'h3333_3333));
      tick();
      // reset during WAIT, late rvalid afterwards
      cyc(0, 1, mk(1, 1, 8, 0, 32'h20), 1, 0, 0);
      cyc(1, 0, '0, 1, 0, 0);
      step(0, 0, '0, 1, 1, 32'h7777_7777);
      check("late_rv", 70'({ms_to_ws_valid, ms_to_ds_load_pending, mem_forward_valid, ms_allowin}), 70'(4'b0001));
      tick();
      step(0, 0, '0, 1, 0, 0);
      check("late_rv2", 70'({ms_to_ws_valid, ms_to_ds_dest}), 70'(0));
      tick();
      // stale dest left in the bus register
      cyc(0, 1, mk(0, 1, 9, 32'h99, 32'h30), 1, 0, 0);
      cyc(0, 0, '0, 1, 0, 0);
      step(0, 0, '0, 1, 0, 0);
      check("stale_dest", 70'({ms_to_ds_dest, mem_forward_valid}), 70'(0));
      tick();
      // random traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(99) == 0, $urandom_range(1),
             mk($urandom_range(1), $urandom_range(1), 5'($urandom), $urandom, $urandom),
             $urandom_range(9) < 7, $urandom_range(9) < 3, $urandom);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the writeback stage of the 5-stage LoongArch CPU.
- Latches the execute-to-memory bus and waits for the data SRAM load response, which may take one or more cycles.
- Buffers the returned load data while writeback is stalled, selects the final result (load data or ALU result), and sends it on to writeback.
- Also drives the memory-stage forwarding and hazard signals back to the decode stage.

Parameters:
- ES_TO_MS_BUS_WD, 71, width of the incoming bus: {res_from_mem[1], gr_we[1], dest[5], alu_result[32], pc[32]}, MSB first.
- MS_TO_WS_BUS_WD, 70, width of the outgoing bus: {gr_we[1], dest[5], final_result[32], pc[32]}, MSB first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- es_to_ms_valid  input  1  execute stage presents a valid instruction.
- es_to_ms_bus  input  ES_TO_MS_BUS_WD  instruction payload from execute.
- ms_allowin  output  1  this stage can accept an instruction this cycle.
- ws_allowin  input  1  writeback stage can accept an instruction.
- ms_to_ws_valid  output  1  valid, completed instruction offered to writeback.
- ms_to_ws_bus  output  MS_TO_WS_BUS_WD  payload to writeback.
- data_sram_rvalid  input  1  load response valid this cycle.
- data_sram_rdata  input  32  load response data; meaningful only when data_sram_rvalid=1.
- ms_to_ds_dest  output  5  destination register, forced to 0 when the stage is invalid.
- ms_to_ds_load_pending  output  1  a load is held here and its data has not yet arrived.
- mem_forward_valid  output  1  forwarding data is valid.
- mem_forward_addr  output  5  forwarded register number.
- mem_forward_data  output  32  forwarded value.

Behaviour:
- Reset:
  - ms_valid=0, got_rdata=0, rdata_buf=0.
  - Consequently ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_dest=0, ms_to_ds_load_pending=0, mem_forward_valid=0.
  - The bus register is not reset; all outputs derived from it are masked by ms_valid.
- Pipeline register:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - When ms_allowin=1: ms_valid <= es_to_ms_valid.
  - The bus is captured when es_to_ms_valid && ms_allowin.
  - An instruction leaving and a new instruction entering in the same cycle is a legal back-to-back transfer with no bubble.
- Load wait state, two states (WAIT / DONE), meaningful only while ms_valid && res_from_mem:
  - WAIT (got_rdata=0): on data_sram_rvalid, rdata_buf <= data_sram_rdata and got_rdata <= 1, moving to DONE.
  - DONE (got_rdata=1): stays in DONE until the instruction transfers, i.e. ms_to_ws_valid && ws_allowin. At that point got_rdata <= 0.
  - If a new load enters in the same cycle the old one leaves, got_rdata is still cleared, so the new load starts in WAIT.
  - data_sram_rvalid is ignored when ms_valid=0, when the held instruction is not a load, or when got_rdata=1.
- Ready and result selection:
  - ms_ready_go = !res_from_mem || data_sram_rvalid || got_rdata.
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - final_result: alu_result for non-loads; data_sram_rdata if got_rdata=0; otherwise rdata_buf.
  - Load-to-writeback latency is zero cycles after the rvalid cycle; the data passes straight through in that cycle.
- Hazard and forwarding outputs:
  - ms_to_ds_load_pending = ms_valid && res_from_mem && !ms_ready_go.
  - mem_forward_valid = ms_valid && gr_we && ms_ready_go.
  - mem_forward_addr = dest; mem_forward_data = final_result.
  - Forwarding of r0 is not filtered here; that is decode's responsibility.
- Reset while a load is waiting: the instruction is dropped and got_rdata is cleared. A late rvalid arriving afterwards is ignored because ms_valid=0.

Optional Feature:
- Macro: MEM_LOAD_STALL_CNT_EN.
- When defined:
  - Adds output ms_load_stall_cnt [31:0].
  - Increments by 1 every cycle in which ms_to_ds_load_pending=1, and wraps at 0xFFFFFFFF to 0.
  - Reset value 0.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Non-load ALU op (gr_we=1, dest=5, alu_result=0x1234) with ws_allowin=1 → ms_to_ws_valid=1 the cycle after capture; final_result=0x1234; mem_forward_valid=1, addr=5, data=0x1234.
- Load to dest=7 with rvalid arriving 3 cycles after capture, rdata=0xDEADBEEF → ms_to_ds_load_pending=1 for 3 cycles; ms_allowin=0; in the rvalid cycle ms_to_ws_valid=1 and final_result=0xDEADBEEF. With the macro defined, the counter reads 3.
- Load with rvalid (rdata=0xCAFEF00D) while ws_allowin=0 for 2 more cycles, and rdata changed to 0 afterwards → final_result holds 0xCAFEF00D from rdata_buf until the transfer; got_rdata=0 after the transfer.
- Back-to-back loads, second arriving in the cycle the first leaves → the second waits for its own rvalid; no data is carried over from the first.
- Reset asserted during WAIT, rvalid pulsed one cycle after reset released → ms_to_ws_valid stays 0, got_rdata=0, and the outputs hold their reset values.
- ms_valid=0 with dest field=9 left in the bus register → ms_to_ds_dest=0 and mem_forward_valid=0.
